// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, opcodes,
// datapath select codes and the control word passed from decode to the top.
package ctrl_pkg;

    localparam int OPC_W = 6;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [OPC_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPC_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPC_W-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OPC_W-1:0] OP_AND   = 6'b010000;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPC_W-1:0] OP_OR    = 6'b010100;
    localparam logic [OPC_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OPC_W-1:0] OP_SLT   = 6'b100111;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'b100110;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'b110101;
    localparam logic [OPC_W-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OPC_W-1:0] OP_J     = 6'b111000;
    localparam logic [OPC_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'b111010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;

    localparam logic [1:0] PC_NEXT = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_RS   = 2'b10;
    localparam logic [1:0] PC_JMP  = 2'b11;

    localparam logic [1:0] DST_R31 = 2'b00;
    localparam logic [1:0] DST_RT  = 2'b01;
    localparam logic [1:0] DST_RD  = 2'b10;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_MEM,
        CL_BR,
        CL_JMP,
        CL_NOP
    } op_class_t;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       ins_mem_rw;
        logic       reg_wre;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_sel;
        logic [1:0] reg_dst;
        logic       wr_reg_d_src;
        logic       db_data_src;
        logic       m_rd;
        logic       m_wr;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
    } ctrl_word_t;

    function automatic op_class_t op_class(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_OR,
            OP_SLL, OP_SLT, OP_SLTI:   return CL_ALU;
            OP_SW, OP_LW:              return CL_MEM;
            OP_BEQ, OP_BNE, OP_BLTZ:   return CL_BR;
            OP_J, OP_JR, OP_JAL:       return CL_JMP;
            default:                   return CL_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map of (state, opcode, ALU flags) to the datapath control word.
// Reset gating of the write strobes is applied by the parent.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t           i_state,
    input  logic [OPC_W-1:0] i_opc,
    input  logic             i_halt,
    input  logic             i_zero,
    input  logic             i_sign,
    output ctrl_word_t       o_ctrl
);

    op_class_t w_class;
    logic      w_taken;

    assign w_class = op_class(i_opc);
    assign w_taken = ((i_opc == OP_BEQ) &&  i_zero) ||
                     ((i_opc == OP_BNE) && !i_zero) ||
                     ((i_opc == OP_BLTZ) && i_sign);

    always_comb begin
        // NOTE: every field gets a default first so no path leaves one unassigned (no latch).
        o_ctrl              = '0;
        o_ctrl.ext_sel      = 1'b1;
        o_ctrl.wr_reg_d_src = 1'b1;

        // Opcode-driven selects stay constant from ID to the end of the
        // instruction; IF uses the neutral defaults since op is still stale.
        if (i_state != S_IF) begin
            case (i_opc)
                OP_ADD:   o_ctrl.reg_dst = DST_RD;
                OP_SUB:   begin o_ctrl.alu_op = ALU_SUB; o_ctrl.reg_dst = DST_RD; end
                OP_ADDIU: begin o_ctrl.alu_src_b = 1'b1; o_ctrl.reg_dst = DST_RT; end
                OP_AND:   begin o_ctrl.alu_op = ALU_AND; o_ctrl.reg_dst = DST_RD; end
                OP_ANDI:  begin
                    o_ctrl.alu_op    = ALU_AND;
                    o_ctrl.alu_src_b = 1'b1;
                    o_ctrl.ext_sel   = 1'b0;
                    o_ctrl.reg_dst   = DST_RT;
                end
                OP_ORI:   begin
                    o_ctrl.alu_op    = ALU_OR;
                    o_ctrl.alu_src_b = 1'b1;
                    o_ctrl.ext_sel   = 1'b0;
                    o_ctrl.reg_dst   = DST_RT;
                end
                OP_OR:    begin o_ctrl.alu_op = ALU_OR;  o_ctrl.reg_dst = DST_RD; end
                OP_SLL:   begin
                    o_ctrl.alu_op    = ALU_SLL;
                    o_ctrl.alu_src_a = 1'b1;
                    o_ctrl.reg_dst   = DST_RD;
                end
                OP_SLT:   begin o_ctrl.alu_op = ALU_SLT; o_ctrl.reg_dst = DST_RD; end
                OP_SLTI:  begin
                    o_ctrl.alu_op    = ALU_SLT;
                    o_ctrl.alu_src_b = 1'b1;
                    o_ctrl.reg_dst   = DST_RT;
                end
                OP_SW:    o_ctrl.alu_src_b = 1'b1;
                OP_LW:    begin o_ctrl.alu_src_b = 1'b1; o_ctrl.reg_dst = DST_RT; end
                OP_BEQ, OP_BNE, OP_BLTZ: o_ctrl.alu_op = ALU_SUB;
                default:  ;
            endcase
        end

        case (i_state)
            S_IF: begin
                o_ctrl.ir_wre     = 1'b1;
                o_ctrl.ins_mem_rw = 1'b1;
            end
            S_ID: begin
                if (!i_halt) begin
                    if (i_opc == OP_JAL) begin
                        o_ctrl.reg_wre      = 1'b1;
                        o_ctrl.wr_reg_d_src = 1'b0;
                        o_ctrl.reg_dst      = DST_R31;
                    end
                    if (i_opc == OP_J || i_opc == OP_JAL) o_ctrl.pc_src = PC_JMP;
                    if (i_opc == OP_JR)                   o_ctrl.pc_src = PC_RS;
                    if (w_class == CL_JMP || w_class == CL_NOP) o_ctrl.pc_wre = 1'b1;
                end
            end
            S_EXE_BR: begin
                o_ctrl.pc_wre = 1'b1;
                if (w_taken) o_ctrl.pc_src = PC_BR;
            end
            S_MEM: begin
                if (i_opc == OP_LW) begin
                    o_ctrl.m_rd        = 1'b1;
                    o_ctrl.db_data_src = 1'b1;
                end else begin
                    o_ctrl.m_wr   = 1'b1;
                    o_ctrl.pc_wre = 1'b1;
                end
            end
            S_WB_LD: begin
                o_ctrl.m_rd        = 1'b1;
                o_ctrl.db_data_src = 1'b1;
                o_ctrl.reg_wre     = 1'b1;
                o_ctrl.pc_wre      = 1'b1;
            end
            S_WB_AL: begin
                o_ctrl.reg_wre = 1'b1;
                o_ctrl.pc_wre  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: state register and next-state logic; the
// per-state control word comes from ctrl_decode.
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int              OP_W    = 6,
    parameter int              ALUOP_W = 3,
    parameter logic [OP_W-1:0] HALT_OP = {OP_W{1'b1}}
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    input  logic               sign,
    output logic               PCWre,
    output logic               IRWre,
    output logic               InsMemRW,
    output logic               RegWre,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic               ExtSel,
    output logic [1:0]         RegDst,
    output logic               WrRegDSrc,
    output logic               DBDataSrc,
    output logic               mRD,
    output logic               mWR,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state_out
);

    state_t           r_state;
    state_t           w_next;
    logic [OPC_W-1:0] w_opc;
    logic             w_halt;
    op_class_t        w_class;
    ctrl_word_t       w_ctrl;

    assign w_opc   = op[OPC_W-1:0];
    assign w_halt  = (op == HALT_OP);
    assign w_class = op_class(w_opc);

    always_comb begin
        w_next = S_IF;
        case (r_state)
            S_IF:     w_next = S_ID;
            S_ID: begin
                if (w_halt) begin
                    w_next = S_ID;
                end else begin
                    case (w_class)
                        CL_ALU:  w_next = S_EXE_AL;
                        CL_MEM:  w_next = S_EXE_LS;
                        CL_BR:   w_next = S_EXE_BR;
                        default: w_next = S_IF;
                    endcase
                end
            end
            S_EXE_LS: w_next = S_MEM;
            S_MEM:    w_next = (w_opc == OP_LW) ? S_WB_LD : S_IF;
            S_EXE_AL: w_next = S_WB_AL;
            default:  w_next = S_IF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge CLK) begin
        if (Reset) r_state <= S_IF;
        else       r_state <= w_next;
    end

    ctrl_decode u_decode (
        .i_state (r_state),
        .i_opc   (w_opc),
        .i_halt  (w_halt),
        .i_zero  (zero),
        .i_sign  (sign),
        .o_ctrl  (w_ctrl)
    );

    // State-changing strobes are masked while Reset is high so an aborted
    // instruction never commits a partial write.
    assign PCWre     = w_ctrl.pc_wre  & ~Reset;
    assign IRWre     = w_ctrl.ir_wre  & ~Reset;
    assign RegWre    = w_ctrl.reg_wre & ~Reset;
    assign mWR       = w_ctrl.m_wr    & ~Reset;
    assign InsMemRW  = w_ctrl.ins_mem_rw;
    assign ALUSrcA   = w_ctrl.alu_src_a;
    assign ALUSrcB   = w_ctrl.alu_src_b;
    assign ExtSel    = w_ctrl.ext_sel;
    assign RegDst    = w_ctrl.reg_dst;
    assign WrRegDSrc = w_ctrl.wr_reg_d_src;
    assign DBDataSrc = w_ctrl.db_data_src;
    assign mRD       = w_ctrl.m_rd;
    assign PCSrc     = w_ctrl.pc_src;
    assign ALUOp     = ALUOP_W'(w_ctrl.alu_op);
    assign state_out = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: table of instructions expanded into
// per-cycle expectations on a scoreboard queue, plus reset and halt sequences.
module tb_multi_cycle_ctrl;

    logic       CLK;
    logic       Reset;
    logic [5:0] op;
    logic       zero;
    logic       sign;
    logic       PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, ExtSel;
    logic [1:0] RegDst;
    logic       WrRegDSrc, DBDataSrc, mRD, mWR;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic [2:0] state_out;

    multi_cycle_ctrl dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .op        (op),
        .zero      (zero),
        .sign      (sign),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .InsMemRW  (InsMemRW),
        .RegWre    (RegWre),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ExtSel    (ExtSel),
        .RegDst    (RegDst),
        .WrRegDSrc (WrRegDSrc),
        .DBDataSrc (DBDataSrc),
        .mRD       (mRD),
        .mWR       (mWR),
        .PCSrc     (PCSrc),
        .ALUOp     (ALUOp),
        .state_out (state_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0]      op;
        logic            zero;
        logic            sign;
        int              ncyc;
        logic [4:0][2:0] seq;
        logic            regwr;
        logic            memrd;
        logic            memwr;
        logic [1:0]      pcsrc;
        logic [1:0]      regdst;
        logic [2:0]      aluop;
        logic            wrsrc;
        logic            srca;
        logic            srcb;
        logic            ext;
    } vec_t;

    typedef struct {
        string      tag;
        logic [2:0] state;
        logic       irwre;
        logic       pcwre;
        logic       regwre;
        logic       mrd;
        logic       mwr;
        logic [1:0] pcsrc;
        logic       srca;
        logic       srcb;
        logic       ext;
        logic       chk_alu;
        logic [2:0] aluop;
        logic       chk_dst;
        logic [1:0] regdst;
        logic       wrsrc;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] o, input logic z, input logic s,
                                input int n, input logic [2:0] s2, input logic [2:0] s3,
                                input logic [2:0] s4, input logic rw, input logic mr,
                                input logic mw, input logic [1:0] pcs, input logic [1:0] dst,
                                input logic [2:0] alu, input logic wsrc, input logic sa,
                                input logic sb_, input logic ex);
        vec_t v;
        v.op = o; v.zero = z; v.sign = s; v.ncyc = n;
        v.seq[0] = 3'd0; v.seq[1] = 3'd1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
        v.regwr = rw; v.memrd = mr; v.memwr = mw; v.pcsrc = pcs; v.regdst = dst;
        v.aluop = alu; v.wrsrc = wsrc; v.srca = sa; v.srcb = sb_; v.ext = ex;
        return v;
    endfunction

    task automatic compare(input exp_t e);
        check({e.tag, " state"},  {5'd0, state_out}, {5'd0, e.state});
        check({e.tag, " IRWre"},  {7'd0, IRWre},     {7'd0, e.irwre});
        check({e.tag, " InsMemRW"}, {7'd0, InsMemRW}, {7'd0, e.irwre});
        check({e.tag, " PCWre"},  {7'd0, PCWre},     {7'd0, e.pcwre});
        check({e.tag, " RegWre"}, {7'd0, RegWre},    {7'd0, e.regwre});
        check({e.tag, " mRD"},    {7'd0, mRD},       {7'd0, e.mrd});
        check({e.tag, " DBDataSrc"}, {7'd0, DBDataSrc}, {7'd0, e.mrd});
        check({e.tag, " mWR"},    {7'd0, mWR},       {7'd0, e.mwr});
        check({e.tag, " PCSrc"},  {6'd0, PCSrc},     {6'd0, e.pcsrc});
        check({e.tag, " ALUSrcA"}, {7'd0, ALUSrcA},  {7'd0, e.srca});
        check({e.tag, " ALUSrcB"}, {7'd0, ALUSrcB},  {7'd0, e.srcb});
        check({e.tag, " ExtSel"}, {7'd0, ExtSel},    {7'd0, e.ext});
        if (e.chk_alu) check({e.tag, " ALUOp"}, {5'd0, ALUOp}, {5'd0, e.aluop});
        if (e.chk_dst) begin
            check({e.tag, " RegDst"},    {6'd0, RegDst},    {6'd0, e.regdst});
            check({e.tag, " WrRegDSrc"}, {7'd0, WrRegDSrc}, {7'd0, e.wrsrc});
        end
    endtask

    // Assert Reset for one clock with the new instruction on op; returns in the
    // IF cycle right after release, sampled away from the rising edge.
    task automatic start_instr(input logic [5:0] o, input logic z, input logic s);
        @(negedge CLK);
        Reset = 1'b1; op = o; zero = z; sign = s;
        @(negedge CLK);
        Reset = 1'b0;
        #1;
    endtask

    initial begin
        Reset = 1'b1; op = 6'd0; zero = 1'b0; sign = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check("reset state", {5'd0, state_out}, 8'd0);
        check("reset IRWre gated", {7'd0, IRWre}, 8'd0);
        check("reset PCWre gated", {7'd0, PCWre}, 8'd0);

        //     op         z  s  n  s2 s3 s4 rw mr mw pcs    dst    alu     ws sa sb ex
        vecs.push_back(mk(6'b000000, 0, 0, 4, 6, 7, 0, 1, 0, 0, 2'b00, 2'b10, 3'b000, 1, 0, 0, 1)); // add
        vecs.push_back(mk(6'b000001, 1, 0, 4, 6, 7, 0, 1, 0, 0, 2'b00, 2'b10, 3'b001, 1, 0, 0, 1)); // sub
        vecs.push_back(mk(6'b000010, 0, 0, 4, 6, 7, 0, 1, 0, 0, 2'b00, 2'b01, 3'b000, 1, 0, 1, 1)); // addiu
        vecs.push_back(mk(6'b010000, 0, 0, 4, 6, 7, 0, 1, 0, 0, 2'b00, 2'b10, 3'b100, 1, 0, 0, 1)); // and
        vecs.push_back(mk(6'b010001, 0, 0, 4, 6, 7, 0, 1, 0, 0, 2'b00, 2'b01, 3'b100, 1, 0, 1, 0)); // andi
        vecs.push_back(mk(6'b010010, 0, 0, 4, 6, 7, 0, 1, 0, 0, 2'b00, 2'b01, 3'b101, 1, 0, 1, 0)); // ori
        vecs.push_back(mk(6'b010100, 0, 0, 4, 6, 7, 0, 1, 0, 0, 2'b00, 2'b10, 3'b101, 1, 0, 0, 1)); // or
        vecs.push_back(mk(6'b011000, 0, 0, 4, 6, 7, 0, 1, 0, 0, 2'b00, 2'b10, 3'b011, 1, 1, 0, 1)); // sll
        vecs.push_back(mk(6'b100111, 0, 0, 4, 6, 7, 0, 1, 0, 0, 2'b00, 2'b10, 3'b010, 1, 0, 0, 1)); // slt
        vecs.push_back(mk(6'b100110, 0, 0, 4, 6, 7, 0, 1, 0, 0, 2'b00, 2'b01, 3'b010, 1, 0, 1, 1)); // slti
        vecs.push_back(mk(6'b110001, 0, 0, 5, 2, 3, 4, 1, 1, 0, 2'b00, 2'b01, 3'b000, 1, 0, 1, 1)); // lw
        vecs.push_back(mk(6'b110000, 0, 0, 4, 2, 3, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 1, 0, 1, 1)); // sw
        vecs.push_back(mk(6'b110100, 1, 0, 3, 5, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b001, 1, 0, 0, 1)); // beq taken
        vecs.push_back(mk(6'b110100, 0, 0, 3, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b001, 1, 0, 0, 1)); // beq not
        vecs.push_back(mk(6'b110101, 0, 0, 3, 5, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b001, 1, 0, 0, 1)); // bne taken
        vecs.push_back(mk(6'b110101, 1, 0, 3, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b001, 1, 0, 0, 1)); // bne not
        vecs.push_back(mk(6'b110110, 0, 1, 3, 5, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b001, 1, 0, 0, 1)); // bltz taken
        vecs.push_back(mk(6'b110110, 1, 0, 3, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b001, 1, 0, 0, 1)); // bltz not
        vecs.push_back(mk(6'b111000, 0, 0, 2, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, 1, 0, 0, 1)); // j
        vecs.push_back(mk(6'b111010, 0, 0, 2, 0, 0, 0, 1, 0, 0, 2'b11, 2'b00, 3'b000, 0, 0, 0, 1)); // jal
        vecs.push_back(mk(6'b111001, 0, 0, 2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b000, 1, 0, 0, 1)); // jr
        vecs.push_back(mk(6'b001111, 0, 0, 2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0, 0, 1)); // nop

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            for (int k = 0; k <= v.ncyc; k++) begin
                exp_t e;
                logic last;
                logic [2:0] st;
                last    = (k == v.ncyc - 1);
                st      = (k == v.ncyc) ? 3'd0 : v.seq[k];
                e.tag   = $sformatf("v%0d op=%b c%0d", i, v.op, k);
                e.state = st;
                e.irwre = (k == 0) || (k == v.ncyc);
                e.pcwre = last;
                e.regwre = last && v.regwr;
                e.mrd   = v.memrd && (st == 3'd3 || st == 3'd4);
                e.mwr   = last && v.memwr;
                e.pcsrc = last ? v.pcsrc : 2'b00;
                e.srca  = (k >= 1 && k < v.ncyc) ? v.srca : 1'b0;
                e.srcb  = (k >= 1 && k < v.ncyc) ? v.srcb : 1'b0;
                e.ext   = (k >= 1 && k < v.ncyc) ? v.ext : 1'b1;
                e.chk_alu = (k >= 2 && k < v.ncyc);
                e.aluop = v.aluop;
                e.chk_dst = last && v.regwr;
                e.regdst = v.regdst;
                e.wrsrc = v.wrsrc;
                sb.push_back(e);
            end
            start_instr(v.op, v.zero, v.sign);
            while (sb.size() > 0) begin
                compare(sb.pop_front());
                if (sb.size() > 0) begin
                    @(negedge CLK);
                    #1;
                end
            end
        end

        // Reset held three cycles while in WB_AL of an add.
        start_instr(6'b000000, 1'b0, 1'b0);
        for (int i = 0; i < 10 && state_out != 3'd7; i++) begin
            @(negedge CLK);
            #1;
        end
        check("rst reach WB_AL", {5'd0, state_out}, 8'd7);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("rst hold%0d RegWre", i), {7'd0, RegWre}, 8'd0);
            check($sformatf("rst hold%0d PCWre", i),  {7'd0, PCWre},  8'd0);
            @(negedge CLK);
        end
        check("rst hold state", {5'd0, state_out}, 8'd0);
        Reset = 1'b0;
        #1;
        check("rst release state", {5'd0, state_out}, 8'd0);
        check("rst release IRWre", {7'd0, IRWre}, 8'd1);
        @(negedge CLK);
        #1;
        check("rst release next", {5'd0, state_out}, 8'd1);

        // Halt parks in ID without ever strobing PCWre until Reset.
        start_instr(6'b111111, 1'b0, 1'b0);
        check("halt IF", {5'd0, state_out}, 8'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #1;
            check($sformatf("halt c%0d state", i), {5'd0, state_out}, 8'd1);
            check($sformatf("halt c%0d PCWre", i), {7'd0, PCWre}, 8'd0);
        end
        Reset = 1'b1;
        @(negedge CLK);
        #1;
        check("halt reset state", {5'd0, state_out}, 8'd0);
        check("halt reset IRWre gated", {7'd0, IRWre}, 8'd0);
        Reset = 1'b0;
        #1;
        check("halt release IRWre", {7'd0, IRWre}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
